piso_frame_ctrl: RTL and testbench

//   Sequences a WIDTH-bit parallel-in/serial-out shifter into framed serial output.

---
 rtl/piso_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_piso_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_frame_ctrl.sv
// piso_frame_ctrl: frames one parallel word per valid/ready handshake into a
// serial stream of start(0), data MSB-first, optional even parity, stop(1),
// holding every serial bit for DIV clocks. The line idles high.
module piso_frame_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DIV       = 4,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic             HAS_PAR  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   sh_shift;
    logic               par_q, par_d;
    logic               sout_q, sout_d;
    logic               done_q, done_d;
    logic               div_last;

    // Handshake and status flags come straight from the state register
    assign din_ready = (state_q == ST_IDLE);
    assign busy      = ~din_ready;
    assign sout      = sout_q;
    assign frame_done = done_q;

    // State, counters, shifter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            sout_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; sout_d is the line value for the clock after the edge
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        sout_d   = sout_q;
        done_d   = 1'b0;
        div_last = (div_q == DIV_LAST);
        sh_shift = sh_q << 1;

        case (state_q)
            ST_IDLE: begin
                sout_d = 1'b1;
                if (din_valid) begin
                    sh_d    = din;
                    par_d   = ^din;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                    sout_d  = 1'b0;
                end
            end

            ST_START: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_DATA;
                    sout_d  = sh_q[WIDTH-1];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (div_last) begin
                    div_d = '0;
                    sh_d  = sh_shift;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = ST_PARITY;
                            sout_d  = par_q;
                        end else begin
                            state_d = ST_STOP;
                            sout_d  = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sout_d = sh_shift[WIDTH-1];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_PARITY: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_STOP;
                    sout_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                    sout_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                bit_d   = '0;
                sout_d  = 1'b1;
            end
        endcase

        // Pulse lands on the final stop-bit clock, including the DIV=1 case
        done_d = (state_d == ST_STOP) && (div_d == DIV_LAST);
    end

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Bench for piso_frame_ctrl: three instances (4/4/parity, 4/4/no parity,
// 4/1/parity) driven from scenario tasks against a queue of expected
// per-clock {sout, frame_done, din_ready} values.
module tb_piso_frame_ctrl;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] dv;
    logic [3:0] din [3];
    logic [2:0] rdy;
    logic [2:0] sout;
    logic [2:0] busy;
    logic [2:0] done;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic s;
        logic d;
        logic r;
    } exp_t;

    exp_t q[$];

    piso_frame_ctrl #(.WIDTH(4), .DIV(4), .PARITY_EN(1)) u0 (
        .clk(clk), .rst(rst[0]), .din_valid(dv[0]), .din(din[0]),
        .din_ready(rdy[0]), .sout(sout[0]), .busy(busy[0]), .frame_done(done[0]));

    piso_frame_ctrl #(.WIDTH(4), .DIV(4), .PARITY_EN(0)) u1 (
        .clk(clk), .rst(rst[1]), .din_valid(dv[1]), .din(din[1]),
        .din_ready(rdy[1]), .sout(sout[1]), .busy(busy[1]), .frame_done(done[1]));

    piso_frame_ctrl #(.WIDTH(4), .DIV(1), .PARITY_EN(1)) u2 (
        .clk(clk), .rst(rst[2]), .din_valid(dv[2]), .din(din[2]),
        .din_ready(rdy[2]), .sout(sout[2]), .busy(busy[2]), .frame_done(done[2]));

    // Rising edges at 10, 20, 30 ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int par_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    // Line value for serial slot s of a frame carrying d
    function automatic logic slot_bit(input int par, input logic [3:0] d, input int s);
        if (s == 0) return 1'b0;
        if (s <= 4) return d[4 - s];
        if (s == 5 && par != 0) return ^d;
        return 1'b1;
    endfunction

    function automatic void push_frame(input int i, input logic [3:0] d);
        int dvs;
        int par;
        int f;
        exp_t e;
        dvs = div_of(i);
        par = par_of(i);
        f   = (6 + par) * dvs;
        for (int k = 0; k < f; k++) begin
            e.s = slot_bit(par, d, k / dvs);
            e.d = (k == f - 1);
            e.r = 1'b0;
            q.push_back(e);
        end
    endfunction

    function automatic void push_idle(input int n);
        exp_t e;
        e.s = 1'b1;
        e.d = 1'b0;
        e.r = 1'b1;
        for (int k = 0; k < n; k++) q.push_back(e);
    endfunction

    // Present a word for one accept edge; returns just after that edge (T0)
    task automatic accept(input int i, input logic [3:0] w);
        @(negedge clk);
        din[i] = w;
        dv[i]  = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst = 3'b111;
        dv  = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 4'h0;
        #3;
        for (int i = 0; i < 3; i++) begin
            got = {sout[i], done[i], rdy[i], busy[i]};
            checks++;
            if (got !== 4'b1010) begin
                fails++;
                $display("FAIL reset_in_progress inst=%0d got %b expected 1010", i, got);
            end
        end
        #22;
        rst = 3'b000;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                got = {sout[i], done[i], rdy[i], busy[i]};
                checks++;
                if (got !== 4'b1010) begin
                    fails++;
                    $display("FAIL reset_idle inst=%0d clk=%0d got %b expected 1010", i, c, got);
                end
            end
        end
    endtask

    task automatic test_frame(input int i, input logic [3:0] w, input string name);
        exp_t e;
        logic [3:0] got;
        logic [3:0] want;
        int k;
        q.delete();
        push_frame(i, w);
        push_idle(3);
        accept(i, w);
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            if (k == 0) dv[i] = 1'b0;
            e    = q.pop_front();
            got  = {sout[i], done[i], rdy[i], busy[i]};
            want = {e.s, e.d, e.r, ~e.r};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL %s inst=%0d k=%0d got %b expected %b", name, i, k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_parity();
        test_frame(0, 4'b0111, "parity_0111");
        test_frame(0, 4'b1111, "parity_1111");
        test_frame(1, 4'b1010, "no_parity_1010");
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        logic [3:0] got;
        logic [3:0] want;
        int k;
        q.delete();
        push_frame(0, 4'b1010);
        push_idle(8);
        accept(0, 4'b1010);
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            if (k == 0) dv[0] = 1'b0;
            if (k == 10) begin
                din[0] = 4'b0000;
                dv[0]  = 1'b1;
            end
            if (k == 11) dv[0] = 1'b0;
            e    = q.pop_front();
            got  = {sout[0], done[0], rdy[0], busy[0]};
            want = {e.s, e.d, e.r, ~e.r};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL ignore_busy k=%0d got %b expected %b", k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [3:0] got;
        logic [3:0] want;
        int k;
        q.delete();
        push_frame(0, 4'b1010);
        accept(0, 4'b1010);
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            if (k == 0) dv[0] = 1'b0;
            e    = q.pop_front();
            got  = {sout[0], done[0], rdy[0], busy[0]};
            want = {e.s, e.d, e.r, ~e.r};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL pre_reset_frame k=%0d got %b expected %b", k, got, want);
            end
            if (k == 9) begin
                #2;
                rst[0] = 1'b1;
                #1;
                got = {sout[0], done[0], rdy[0], busy[0]};
                checks++;
                if (got !== 4'b1010) begin
                    fails++;
                    $display("FAIL async_reset_immediate got %b expected 1010", got);
                end
                q.delete();
            end
            k++;
        end
        @(negedge clk);
        rst[0] = 1'b0;
        test_frame(0, 4'b1100, "after_reset_1100");
    endtask

    task automatic test_back_to_back(input int i);
        exp_t e;
        logic [3:0] got;
        logic [3:0] want;
        int k;
        int f;
        f = (6 + par_of(i)) * div_of(i);
        q.delete();
        push_frame(i, 4'b1001);
        push_idle(1);
        push_frame(i, 4'b0110);
        push_idle(2);
        accept(i, 4'b1001);
        k = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            if (k == 0) din[i] = 4'b0110;
            if (k == f + 1) dv[i] = 1'b0;
            e    = q.pop_front();
            got  = {sout[i], done[i], rdy[i], busy[i]};
            want = {e.s, e.d, e.r, ~e.r};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL back_to_back inst=%0d k=%0d got %b expected %b", i, k, got, want);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_frame(0, 4'b1010, "frame_1010");
        test_parity();
        test_ignore_busy();
        test_async_reset();
        test_back_to_back(0);
        test_back_to_back(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
